// File: rtl/mdio_mon_pkg.sv
// mdio_phy_mon shared types and register field positions.
// State encoding, MDIO op bundle and PHY status decode helpers.
package mdio_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOST_EXEC,
    ST_HOST_WAIT,
    ST_POLL_BMSR,
    ST_WAIT_BMSR,
    ST_POLL_PHYSR,
    ST_WAIT_PHYSR
  } mon_state_e;

  typedef struct packed {
    logic        rh_wl;
    logic [4:0]  addr;
    logic [15:0] wr_data;
  } mdio_op_t;

  localparam int BMSR_LINK_BIT = 2;
  localparam int PHYSR_SPD_HI  = 15;
  localparam int PHYSR_SPD_LO  = 14;
  localparam int PHYSR_DPX_BIT = 13;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  function automatic logic [1:0] physr_speed(
    input logic [15:0] r
  );
    return r[PHYSR_SPD_HI:PHYSR_SPD_LO];
  endfunction

  function automatic logic physr_duplex(
    input logic [15:0] r
  );
    return r[PHYSR_DPX_BIT];
  endfunction

endpackage

// File: rtl/mdio_poll_timer.sv
// Free-running poll interval counter.
// Emits a one-cycle tick on terminal count, then wraps to zero.
module mdio_poll_timer #(
  parameter logic [23:0] POLL_CYCLES = 24'd250_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [23:0] cnt;

  assign tick = (cnt == POLL_CYCLES - 24'd1);

  // count 0..POLL_CYCLES-1 and wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 24'd1;
    end
  end

endmodule

// File: rtl/mdio_phy_mon.sv
// PHY status poller and host arbiter in front of one MDIO driver.
// Polls BMSR then PHYSR; alternates fairly with a single host user.
import mdio_mon_pkg::*;

module mdio_phy_mon #(
  parameter logic [23:0] POLL_CYCLES = 24'd250_000,
  parameter logic [4:0]  BMSR_ADDR   = 5'h01,
  parameter logic [4:0]  PHYSR_ADDR  = 5'h11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_req,
  input  logic        host_rh_wl,
  input  logic [4:0]  host_addr,
  input  logic [15:0] host_wr_data,
  output logic        host_ready,
  output logic        host_done,
  output logic [15:0] host_rd_data,
  output logic        host_rd_err,
  output logic        op_exec,
  output logic        op_rh_wl,
  output logic [4:0]  op_addr,
  output logic [15:0] op_wr_data,
  input  logic        op_done,
  input  logic [15:0] op_rd_data,
  input  logic        op_rd_ack,
  output logic        link_up,
  output logic [1:0]  speed,
  output logic        duplex,
  output logic        status_valid,
  output logic        phy_err
);

  mon_state_e state_q;
  mon_state_e state_d;

  logic     tick;
  logic     poll_due;
  logic     host_pend;
  logic     last_was_host;
  logic     bmsr_link_q;
  mdio_op_t host_op_q;

  logic host_acc;
  logic host_fin;
  logic bmsr_fin;
  logic physr_fin;

  assign host_acc  = host_req & host_ready;
  assign host_fin  = (state_q == ST_HOST_WAIT) & op_done;
  assign bmsr_fin  = (state_q == ST_WAIT_BMSR) & op_done;
  assign physr_fin = (state_q == ST_WAIT_PHYSR) & op_done;

  mdio_poll_timer #(
    .POLL_CYCLES(POLL_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: host/poll arbitration and op sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (host_pend && poll_due) begin
          state_d = last_was_host ? ST_POLL_BMSR
                                  : ST_HOST_EXEC;
        end else if (host_pend) begin
          state_d = ST_HOST_EXEC;
        end else if (poll_due) begin
          state_d = ST_POLL_BMSR;
        end
      end
      ST_HOST_EXEC:  state_d = ST_HOST_WAIT;
      ST_HOST_WAIT:  if (op_done) state_d = ST_IDLE;
      ST_POLL_BMSR:  state_d = ST_WAIT_BMSR;
      ST_WAIT_BMSR: begin
        if (op_done) begin
          state_d = op_rd_ack ? ST_IDLE
                              : ST_POLL_PHYSR;
        end
      end
      ST_POLL_PHYSR: state_d = ST_WAIT_PHYSR;
      ST_WAIT_PHYSR: if (op_done) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // driver op fields: held stable from exec until done
  always_comb begin
    op_exec    = 1'b0;
    op_rh_wl   = 1'b0;
    op_addr    = '0;
    op_wr_data = '0;
    unique case (state_q)
      ST_HOST_EXEC, ST_HOST_WAIT: begin
        op_exec    = (state_q == ST_HOST_EXEC);
        op_rh_wl   = host_op_q.rh_wl;
        op_addr    = host_op_q.addr;
        op_wr_data = host_op_q.wr_data;
      end
      ST_POLL_BMSR, ST_WAIT_BMSR: begin
        op_exec    = (state_q == ST_POLL_BMSR);
        op_rh_wl   = 1'b1;
        op_addr    = BMSR_ADDR;
      end
      ST_POLL_PHYSR, ST_WAIT_PHYSR: begin
        op_exec    = (state_q == ST_POLL_PHYSR);
        op_rh_wl   = 1'b1;
        op_addr    = PHYSR_ADDR;
      end
      default: ;
    endcase
  end

  // poll request flag: a tick wins over the clear on poll start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_due <= 1'b1;
    end else if (tick) begin
      poll_due <= 1'b1;
    end else if (state_q == ST_POLL_BMSR) begin
      poll_due <= 1'b0;
    end
  end

  // host request capture and ready handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_op_q  <= '0;
      host_pend  <= 1'b0;
      host_ready <= 1'b1;
    end else begin
      if (host_acc) begin
        host_op_q  <= '{rh_wl:   host_rh_wl,
                        addr:    host_addr,
                        wr_data: host_wr_data};
        host_pend  <= 1'b1;
        host_ready <= 1'b0;
      end else if (host_done) begin
        host_ready <= 1'b1;
      end
      if (state_q == ST_HOST_EXEC) begin
        host_pend <= 1'b0;
      end
    end
  end

  // host completion: result capture and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_done    <= 1'b0;
      host_rd_data <= '0;
      host_rd_err  <= 1'b0;
    end else begin
      host_done <= host_fin;
      if (host_fin) begin
        host_rd_data <= op_rd_data;
        host_rd_err  <= op_rd_ack;
      end
    end
  end

  // fairness bit: who got the driver last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_was_host <= 1'b0;
    end else if (host_fin) begin
      last_was_host <= 1'b1;
    end else if (physr_fin) begin
      last_was_host <= 1'b0;
    end
  end

  // decoded PHY status, updated atomically on poll completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bmsr_link_q  <= 1'b0;
      link_up      <= 1'b0;
      speed        <= SPD_10;
      duplex       <= 1'b0;
      status_valid <= 1'b0;
      phy_err      <= 1'b0;
    end else begin
      if (bmsr_fin) begin
        bmsr_link_q <= op_rd_data[BMSR_LINK_BIT];
        if (op_rd_ack) begin
          phy_err <= 1'b1;
          link_up <= 1'b0;
        end
      end
      if (physr_fin) begin
        if (!op_rd_ack) begin
          link_up      <= bmsr_link_q;
          speed        <= physr_speed(op_rd_data);
          duplex       <= physr_duplex(op_rd_data);
          status_valid <= 1'b1;
          phy_err      <= 1'b0;
        end else begin
          phy_err <= 1'b1;
          link_up <= 1'b0;
        end
      end
    end
  end

endmodule
